// File: rtl/data_bus_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_bus_ram_if                                              |
// | Description : Core data-memory bus: request fields in, completion out.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface data_bus_ram_if;
   logic        busReq;
   logic        busWe;
   logic [2:0]  busFunc3;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [31:0] busRData;
   logic        busReady;
   logic        busErr;

   modport master (
      output busReq, busWe, busFunc3, busAddr, busWData,
      input  busRData, busReady, busErr
   );

   modport slave (
      input  busReq, busWe, busFunc3, busAddr, busWData,
      output busRData, busReady, busErr
   );
endinterface
`default_nettype wire

// File: rtl/data_bus_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_bus_ram                                                 |
// | Description : Wait-stated bus-slave data RAM with byte-lane store merging. |
// |               Optional macro DATA_BUS_RAM_MISALIGN_CHECK_EN flags          |
// |               misaligned half/word accesses as errors.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_bus_ram #(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic           clk,
   input  logic           reset,
   data_bus_ram_if.slave  bus
);

   localparam int                    c_DEPTH    = 2**ADDR_WIDTH;
   localparam int                    c_TAG_W    = 32 - ADDR_WIDTH - 2;
   localparam logic [c_TAG_W-1:0]    c_BASE_TAG = BASE_ADDR[31:ADDR_WIDTH+2];
   localparam logic [2:0]            c_WAIT     = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_accept;
   logic [2:0]             r_cnt;
   logic [31:0]            r_addr;
   logic [31:0]            r_wdata;
   logic                   r_we;
   logic [1:0]             r_size;
   logic                   r_ready;
   logic                   r_err;
   logic [31:0]            r_rdata;
   logic [31:0]            r_mem [0:c_DEPTH-1];

   logic [c_TAG_W-1:0]     w_src_tag;
   logic [ADDR_WIDTH-1:0]  w_src_idx;
   logic                   w_src_we;
   logic                   w_misalign;
   logic                   w_err;
   logic                   w_enter_resp;
   logic [ADDR_WIDTH-1:0]  w_wr_idx;
   logic [3:0]             w_be;
   logic [31:0]            w_lane_data;
   logic                   w_commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.busReq) begin
               w_accept = 1'b1;
               w_next   = (c_WAIT != 3'd0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (r_cnt <= 3'd1) begin
               w_next = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // With zero wait states RESP is entered on the accepting edge, so the
   // response is decided from the live bus fields rather than the captures.
   assign w_src_tag    = w_accept ? bus.busAddr[31:ADDR_WIDTH+2] : r_addr[31:ADDR_WIDTH+2];
   assign w_src_idx    = w_accept ? bus.busAddr[ADDR_WIDTH+1:2]  : r_addr[ADDR_WIDTH+1:2];
   assign w_src_we     = w_accept ? bus.busWe : r_we;
   assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

`ifdef DATA_BUS_RAM_MISALIGN_CHECK_EN
   logic [1:0] w_src_lo;
   logic [1:0] w_src_size;
   assign w_src_lo   = w_accept ? bus.busAddr[1:0]  : r_addr[1:0];
   assign w_src_size = w_accept ? bus.busFunc3[1:0] : r_size;
   always_comb begin
      w_misalign = 1'b0;
      if (w_src_size == 2'b01) begin
         w_misalign = w_src_lo[0];
      end else if (w_src_size != 2'b00) begin
         w_misalign = (w_src_lo != 2'b00);
      end
   end
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err = (w_src_tag != c_BASE_TAG) || w_misalign;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= 3'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_cnt   <= c_WAIT;
            r_addr  <= bus.busAddr;
            r_wdata <= bus.busWData;
            r_we    <= bus.busWe;
            r_size  <= bus.busFunc3[1:0];
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
         end
         r_ready <= w_enter_resp;
         r_err   <= w_enter_resp && w_err;
         if (w_enter_resp) begin
            if (w_err) begin
               r_rdata <= 32'd0;
            end else if (!w_src_we) begin
               r_rdata <= r_mem[w_src_idx];
            end
         end
      end
   end

   assign w_wr_idx = r_addr[ADDR_WIDTH+1:2];

   always_comb begin
      w_be        = 4'b1111;
      w_lane_data = r_wdata;
      case (r_size)
         2'b00: begin
            w_be        = 4'b0001 << r_addr[1:0];
            w_lane_data = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{r_wdata[15:0]}};
         end
         default: begin
            w_be        = 4'b1111;
            w_lane_data = r_wdata;
         end
      endcase
   end

   // Commit on the edge leaving RESP; an async reset pulls the state out of
   // RESP first, which is what suppresses the write on an aborted access.
   assign w_commit = (r_state == S_RESP) && r_we && !r_err;

   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
            end
         end
      end
   end

   assign bus.busRData = r_rdata;
   assign bus.busReady = r_ready;
   assign bus.busErr   = r_err;

endmodule
`default_nettype wire
